// File: rtl/reg_dump_pkg.sv
// Shared types and default sizing for the register-file dump reader.
package reg_dump_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_SEND_A = 3'd2,
    S_SEND_B = 3'd3,
    S_DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/reg_file_dump.sv
// Walks the register file two words at a time through its async read ports
// and streams every register out over valid/ready, ending with a done pulse.
module reg_file_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = reg_dump_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_dump_pkg::ADDR_W,
  parameter int DATA_W   = reg_dump_pkg::DATA_W
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              start,
  output logic [ADDR_W-1:0] raddra,
  output logic [ADDR_W-1:0] raddrb,
  input  logic [DATA_W-1:0] douta,
  input  logic [DATA_W-1:0] doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_odd;
  logic [DATA_W-1:0] buf_a;
  logic [DATA_W-1:0] buf_b;
  logic              hs;
  logic              pair_last;

  assign ptr_odd   = ptr + ADDR_W'(1);
  assign hs        = m_valid & m_ready;
  assign pair_last = (ptr_odd == LAST_ADDR);

  // Address pins always follow ptr so the file output is ready on the READ edge.
  assign raddra = ptr;
  assign raddrb = ptr_odd;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      buf_a <= '0;
      buf_b <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ptr <= '0;
          if (start) state <= S_READ;
        end
        S_READ: begin
          buf_a <= douta;
          buf_b <= doutb;
          state <= S_SEND_A;
        end
        S_SEND_A: if (hs) state <= S_SEND_B;
        S_SEND_B: begin
          if (hs) begin
            if (pair_last) begin
              state <= S_DONE;
            end else begin
              ptr   <= ptr + ADDR_W'(2);
              state <= S_READ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_addr  = '0;
    m_last  = 1'b0;
    case (state)
      S_SEND_A: begin
        m_valid = 1'b1;
        m_data  = buf_a;
        m_addr  = ptr;
      end
      S_SEND_B: begin
        m_valid = 1'b1;
        m_data  = buf_b;
        m_addr  = ptr_odd;
        m_last  = pair_last;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: register-file model, beat monitor and
// expected-dump table compared against every captured stream.
module tb_reg_file_dump;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clka = 1'b0;
  logic          rsta_n;
  logic          start;
  logic [AW-1:0] raddra, raddrb;
  logic [DW-1:0] douta, doutb;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic          m_last, busy, done;

  logic [DW-1:0] rf [NR];
  logic          fill, we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          rdy_rand;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  beat_t q[$];
  beat_t vec[NR];

  always #5 clka = ~clka;

  reg_file_dump dut (
    .clka(clka), .rsta_n(rsta_n), .start(start),
    .raddra(raddra), .raddrb(raddrb), .douta(douta), .doutb(doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
    .m_last(m_last), .busy(busy), .done(done)
  );

  // Register file model: combinational reads, write takes effect at the edge.
  assign douta = rf[raddra];
  assign doutb = rf[raddrb];
  always @(posedge clka) begin
    if (fill) begin
      for (int i = 0; i < NR; i++) rf[i] <= (i == 0) ? 32'h0 : (32'hA500_0000 | DW'(i));
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  // Beat monitor plus hold-stability check under backpressure.
  logic          hold_prev = 1'b0;
  logic [DW-1:0] pd;
  logic [AW-1:0] pa;
  logic          pl;
  always @(negedge clka) begin
    if (rsta_n) begin
      if (hold_prev) begin
        checks++;
        if (!m_valid || m_data !== pd || m_addr !== pa || m_last !== pl) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b a=%0d d=%h l=%0b want v=1 a=%0d d=%h l=%0b",
                   m_valid, m_addr, m_data, m_last, pa, pd, pl);
        end
      end
      if (m_valid && m_ready) q.push_back('{m_addr, m_data, m_last});
      if (done) done_cnt++;
      hold_prev = m_valid && !m_ready;
      pd = m_data; pa = m_addr; pl = m_last;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
    if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beat(input logic [AW-1:0] a, input int budget);
    int n = 0;
    while (!(m_valid && m_addr == a) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!(m_valid && m_addr == a)) begin
      errors++;
      $display("FAIL wait_beat: addr %0d not presented within %0d cycles", a, budget);
    end
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
    tick();
    tick();
  endtask

  task automatic check_dump(input string name);
    int n;
    checks++;
    if (q.size() != NR) begin
      errors++;
      $display("FAIL %s_count: got %0d beats want %0d", name, q.size(), NR);
    end
    n = (q.size() < NR) ? q.size() : NR;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (q[i].addr !== vec[i].addr || q[i].data !== vec[i].data || q[i].last !== vec[i].last) begin
        errors++;
        $display("FAIL %s_beat%0d: got a=%0d d=%h l=%0b want a=%0d d=%h l=%0b", name, i,
                 q[i].addr, q[i].data, q[i].last, vec[i].addr, vec[i].data, vec[i].last);
      end
    end
    chk({name, "_done_cnt"}, DW'(done_cnt), 32'd1);
    chk({name, "_idle"}, DW'(busy), 32'd0);
  endtask

  task automatic clear_mon();
    q.delete();
    done_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    for (int i = 0; i < NR; i++) begin
      vec[i].addr = AW'(i);
      vec[i].data = (i == 0) ? 32'h0 : (32'hA500_0000 | DW'(i));
      vec[i].last = (i == NR - 1);
    end
    rsta_n = 1'b0; start = 1'b0; m_ready = 1'b1; rdy_rand = 1'b0;
    fill = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    tick(); tick();
    fill = 1'b0;
    tick();

    // Reset values
    chk("rst_raddra", DW'(raddra), 32'd0);
    chk("rst_raddrb", DW'(raddrb), 32'd1);
    chk("rst_valid",  DW'(m_valid), 32'd0);
    chk("rst_data",   m_data, 32'd0);
    chk("rst_addr",   DW'(m_addr), 32'd0);
    chk("rst_last",   DW'(m_last), 32'd0);
    chk("rst_busy",   DW'(busy), 32'd0);
    chk("rst_done",   DW'(done), 32'd0);
    rsta_n = 1'b1;
    tick();

    // Full dump: latency, 49-cycle done, beat table
    clear_mon();
    pulse_start();
    chk("lat_read_busy",  DW'(busy), 32'd1);
    chk("lat_read_valid", DW'(m_valid), 32'd0);
    chk("lat_read_ra",    DW'(raddra), 32'd0);
    tick();
    chk("lat_a_valid", DW'(m_valid), 32'd1);
    chk("lat_a_addr",  DW'(m_addr), 32'd0);
    chk("lat_a_data",  m_data, 32'd0);
    wait_done(200, cyc);
    chk("done_cycle", DW'(cyc + 2), 32'd49);
    check_dump("full");

    // Backpressure at addr 7
    clear_mon();
    pulse_start();
    wait_beat(5'd7, 100);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", DW'(m_valid), 32'd1);
      chk("bp_data", m_data, 32'hA500_0007);
    end
    m_ready = 1'b1;
    wait_done(200, cyc);
    check_dump("bp");

    // Start while busy, then restart after done
    clear_mon();
    pulse_start();
    wait_beat(5'd10, 100);
    pulse_start();
    wait_done(200, cyc);
    tick(); tick();
    check_dump("busy_start");
    clear_mon();
    pulse_start();
    wait_done(200, cyc);
    check_dump("restart");

    // Async reset while addr 12 presented
    clear_mon();
    pulse_start();
    wait_beat(5'd12, 100);
    #2 rsta_n = 1'b0;
    #1;
    chk("ar_raddra", DW'(raddra), 32'd0);
    chk("ar_raddrb", DW'(raddrb), 32'd1);
    chk("ar_valid",  DW'(m_valid), 32'd0);
    chk("ar_data",   m_data, 32'd0);
    chk("ar_addr",   DW'(m_addr), 32'd0);
    chk("ar_last",   DW'(m_last), 32'd0);
    chk("ar_busy",   DW'(busy), 32'd0);
    tick(); tick(); tick();
    chk("ar_no_done", DW'(done_cnt), 32'd0);
    chk("ar_partial", DW'(q.size()), 32'd12);
    rsta_n = 1'b1;
    tick();
    clear_mon();
    pulse_start();
    tick();
    chk("ar_restart_addr", DW'(m_addr), 32'd0);
    wait_done(200, cyc);
    check_dump("ar_restart");

    // Random m_ready, three dumps
    rdy_rand = 1'b1;
    for (int d = 0; d < 3; d++) begin
      clear_mon();
      pulse_start();
      wait_done(1000, cyc);
      check_dump($sformatf("rand%0d", d));
    end
    rdy_rand = 1'b0;
    m_ready = 1'b1;
    tick();

    // Write coherence: R11 one edge before the 8/9 capture, R9 on it
    clear_mon();
    pulse_start();
    wait_beat(5'd7, 100);
    we = 1'b1; waddr = 5'd11; wdata = 32'h1234_5678;
    tick();
    chk("wc_in_read", DW'({busy, m_valid, raddra}), DW'({1'b1, 1'b0, 5'd8}));
    waddr = 5'd9; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    vec[11].data = 32'h1234_5678;
    wait_done(200, cyc);
    check_dump("wcoh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_dump.md
# reg_file_dump

Debug reader for the CPU register file: on a `start` pulse it walks every register via the two asynchronous read ports, two addresses per read, and streams each word out over a valid/ready interface to the board display/UART path. It is the read-side counterpart of the CPU's single write port. It connects directly to the register file's `raddra`/`raddrb`/`douta`/`doutb` pins, which the CPU datapath releases while `busy` is high.

## Interface
- `NUM_REGS`, 32, registers dumped; even, ≤ 2^ADDR_W
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width
- `clka  in  1  clock; all state updates on rising edge`
- `rsta_n  in  1  reset, asynchronous, active-low`
- `start  in  1  one-cycle request to begin a dump; ignored unless IDLE`
- `raddra  out  ADDR_W  read address A to register file (even address)`
- `raddrb  out  ADDR_W  read address B to register file (odd address)`
- `douta  in  DATA_W  register file read data A (combinational)`
- `doutb  in  DATA_W  register file read data B (combinational)`
- `m_valid  out  1  output word valid`
- `m_ready  in  1  sink accepts word`
- `m_data  out  DATA_W  register contents`
- `m_addr  out  ADDR_W  register index of m_data`
- `m_last  out  1  high with the word for register NUM_REGS-1`
- `busy  out  1  high in every state except IDLE`
- `done  out  1  one-cycle pulse after the last word is accepted`

## Operation
- States: IDLE, READ, SEND_A, SEND_B, DONE.
- IDLE: `ptr`=0. If `start`=1, go to READ.
- READ: drive `raddra`=ptr and `raddrb`=ptr+1. Capture `douta`→buf_a and `doutb`→buf_b at the clock edge. Go to SEND_A.
- SEND_A: `m_valid`=1, `m_data`=buf_a, `m_addr`=ptr. On handshake (`m_valid`&`m_ready`), go to SEND_B.
- SEND_B: `m_valid`=1, `m_data`=buf_b, `m_addr`=ptr+1, `m_last`=(ptr+1==NUM_REGS-1). On handshake:
  - if last, go to DONE;
  - else ptr+=2 and go to READ.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Data is consistent per pair only. Each pair reflects file contents at its READ capture edge. A write landing on that same edge is not visible; the old value is captured.
- `raddra`/`raddrb` are always driven from `ptr`/`ptr+1`, including in IDLE.
- No wrap: `ptr` never exceeds NUM_REGS-2.

## Timing
- Reset values: `raddra`=0, `raddrb`=1, `m_valid`=0, `m_data`=0, `m_addr`=0, `m_last`=0, `busy`=0, `done`=0, state IDLE.
- Start latency: `start` sampled high in IDLE → READ next cycle → first `m_valid` two cycles after the `start` edge.
- Each pair takes at least 3 cycles with `m_ready` held high. A full dump with no backpressure takes 48 cycles from the READ entry to the last handshake. `done` is asserted in the cycle after the last handshake.
- Handshake rules:
  - once `m_valid` rises, `m_data`, `m_addr` and `m_last` are held stable until the handshake;
  - `m_valid` never drops without a handshake;
  - `m_ready` may toggle freely.
- `start` while busy: ignored, no queuing. `start` in the DONE cycle: ignored. `start` is accepted again in IDLE, so the earliest restart is 1 cycle after `done`.
- `rsta_n` low mid-dump: aborts immediately, asynchronously. All outputs take reset values, no `done` is issued, and the partial dump is discarded.

## Structure
- Shared package `reg_dump_pkg`:
  - state enum (IDLE, READ, SEND_A, SEND_B, DONE);
  - default constants NUM_REGS, ADDR_W, DATA_W.
- Single module; no sub-module. The FSM, pointer and two capture registers fit in one block.

## Test plan
- Full dump: bench model R[i]=0xA500_0000|i, R0=0, `m_ready`=1, pulse `start`.
  - Expect 32 beats, addr 0..31, data matching; beat 0 = 0x0000_0000.
  - `m_last` only on addr 31; `done` exactly 1 cycle after beat 31, 49 cycles after the READ entry.
- Backpressure: hold `m_ready`=0 for 5 cycles when addr 7 is presented.
  - `m_valid` stays 1 and `m_data`=0xA500_0007 is stable throughout.
  - The next beat is addr 8; no beat is skipped or duplicated.
- Start while busy: pulse `start` during beat 10.
  - Stream is unaffected and exactly one `done` is issued.
  - A new `start` after `done` produces a second full, correct dump.
- Async reset: drop `rsta_n` while addr 12 is presented.
  - All outputs are at reset values before the next edge; no `done`.
  - After release, `start` begins again at addr 0.
- Write coherence: write R9=0xDEAD_BEEF on the capture edge of pair 8/9, and R11=0x1234_5678 one cycle earlier.
  - Beat 9 shows 0xA500_0009 (old value).
  - Beat 11 shows 0x1234_5678.
- Random `m_ready` (50%), three consecutive dumps: every dump is in order and complete, with exactly one `m_last` and one `done` per dump.
